hazard_unit: RTL and testbench

- ID-stage hazard detector; sits upstream of the EX forwarding logic.
- Forwarding cannot cover some hazards: load-use, ID-resolved branches that need an EX/MEM result, and multi-cycle mul/div occupying EX.
- This block stalls or bubbles the pipeline for those cases and flushes IF/ID on taken branches/jumps.
- Its outputs drive the PC, IF/ID and ID/EX write-enables and bubble muxes.

---
 rtl/hazard_unit_pkg.sv | 22 ++
 rtl/hazard_unit_mc_stall_fsm.sv | 61 ++++++
 rtl/hazard_unit.sv | 106 ++++++++++
 tb/tb_hazard_unit.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/hazard_unit_pkg.sv
// Shared types and constants for the ID-stage hazard unit.
package hazard_unit_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } mc_state_e;

  localparam logic [4:0] REG_ZERO      = 5'd0;
  localparam logic [1:0] MEM_READ_NONE = 2'b00;

  // True when ID actually reads register r; $0 never produces a dependency.
  function automatic logic reg_match(input logic [4:0] r,
                                     input logic [4:0] rs,
                                     input logic [4:0] rt,
                                     input logic       use_rs,
                                     input logic       use_rt);
    return (r != REG_ZERO) && (((rs == r) && use_rs) || ((rt == r) && use_rt));
  endfunction

endpackage

// File: rtl/hazard_unit_mc_stall_fsm.sv
// Multi-cycle (mul/div) stall sequencer: holds EX for MC_LATENCY cycles,
// then raises mul_done_o for one cycle while EX drains.
module mc_stall_fsm
  import hazard_unit_pkg::*;
#(
  parameter int unsigned MC_LATENCY = 4,
  parameter int unsigned CNT_W      = 4
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic multi_cycle_i,
  output logic mc_stall_o,
  output logic mul_done_o
);

  mc_state_e          state_q, state_d;
  logic [CNT_W-1:0]   count_q, count_d;

  // Next state; multi_cycle_i is only looked at in IDLE since EX keeps it high while held.
  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    mc_stall_o = 1'b0;
    mul_done_o = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (multi_cycle_i) begin
          mc_stall_o = 1'b1;
          count_d    = CNT_W'(MC_LATENCY - 1);
          state_d    = ST_BUSY;
        end
      end
      ST_BUSY: begin
        mc_stall_o = 1'b1;
        count_d    = count_q - CNT_W'(1);
        if (count_q == CNT_W'(1)) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        mul_done_o = 1'b1;
        state_d    = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        count_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/hazard_unit.sv
// ID-stage hazard detector: load-use / branch-operand stalls, mul/div EX hold,
// and IF/ID flush on redirect. Optional perf counters via HAZARD_PERF_CNT_EN.
module hazard_unit
  import hazard_unit_pkg::*;
#(
  parameter int unsigned MC_LATENCY = 4,
  parameter int unsigned CNT_W      = 4
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic [4:0] rs_ID,
  input  logic [4:0] rt_ID,
  input  logic       UsesRs_ID,
  input  logic       UsesRt_ID,
  input  logic       BranchID,
  input  logic       TakenID,
  input  logic [4:0] writeRegisterEX,
  input  logic       RegWriteEX,
  input  logic [1:0] MemReadEX,
  input  logic [4:0] writeRegisterMEM,
  input  logic [1:0] MemReadMEM,
  input  logic       MultiCycleEX,
  output logic       PCWrite,
  output logic       IFIDWrite,
  output logic       IDEXWrite,
  output logic       IDEXBubble,
  output logic       IFIDFlush,
  output logic       EXMEMBubble,
  output logic       MulDone
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [31:0] StallCount,
  output logic [31:0] FlushCount
`endif
);

  logic mc_stall;
  logic mul_done;
  logic match_ex;
  logic match_mem;
  logic load_use;
  logic br_haz;

  mc_stall_fsm #(
    .MC_LATENCY (MC_LATENCY),
    .CNT_W      (CNT_W)
  ) u_mc_stall_fsm (
    .clk_i         (Clk),
    .rst_ni        (Reset),
    .multi_cycle_i (MultiCycleEX),
    .mc_stall_o    (mc_stall),
    .mul_done_o    (mul_done)
  );

  assign match_ex  = reg_match(writeRegisterEX,  rs_ID, rt_ID, UsesRs_ID, UsesRt_ID);
  assign match_mem = reg_match(writeRegisterMEM, rs_ID, rt_ID, UsesRs_ID, UsesRt_ID);
  assign load_use  = (MemReadEX != MEM_READ_NONE) && RegWriteEX && match_ex;
  assign br_haz    = BranchID && ((RegWriteEX && match_ex) ||
                                  ((MemReadMEM != MEM_READ_NONE) && match_mem));

  // Priority: reset, mul/div hold, data-hazard bubble, redirect flush.
  always_comb begin
    PCWrite     = 1'b1;
    IFIDWrite   = 1'b1;
    IDEXWrite   = 1'b1;
    IDEXBubble  = 1'b0;
    IFIDFlush   = 1'b0;
    EXMEMBubble = 1'b0;
    MulDone     = 1'b0;
    if (Reset) begin
      MulDone = mul_done;
      if (mc_stall) begin
        PCWrite     = 1'b0;
        IFIDWrite   = 1'b0;
        IDEXWrite   = 1'b0;
        EXMEMBubble = 1'b1;
      end else if (load_use || br_haz) begin
        // A stalled taken branch is not flushed; it re-resolves next cycle.
        PCWrite    = 1'b0;
        IFIDWrite  = 1'b0;
        IDEXBubble = 1'b1;
      end else if (TakenID) begin
        IFIDFlush = 1'b1;
      end
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_cnt_q;
  logic [31:0] flush_cnt_q;

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (!PCWrite) stall_cnt_q <= stall_cnt_q + 32'd1;
      if (IFIDFlush) flush_cnt_q <= flush_cnt_q + 32'd1;
    end
  end

  assign StallCount = stall_cnt_q;
  assign FlushCount = flush_cnt_q;
`endif

endmodule

// File: tb/tb_hazard_unit.sv
// Scoreboard bench for hazard_unit: stimulus pushes hand-computed expectations,
// a negedge monitor pops and compares every cycle.
module tb_hazard_unit;

  logic       Clk = 1'b0;
  logic       Reset;
  logic [4:0] rs_ID, rt_ID;
  logic       UsesRs_ID, UsesRt_ID, BranchID, TakenID;
  logic [4:0] writeRegisterEX;
  logic       RegWriteEX;
  logic [1:0] MemReadEX;
  logic [4:0] writeRegisterMEM;
  logic [1:0] MemReadMEM;
  logic       MultiCycleEX;
  logic       PCWrite, IFIDWrite, IDEXWrite, IDEXBubble, IFIDFlush, EXMEMBubble, MulDone;
`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] StallCount, FlushCount;
  int unsigned exp_stall_cnt = 0;
  int unsigned exp_flush_cnt = 0;
`endif

  hazard_unit #(.MC_LATENCY(4), .CNT_W(4)) dut (
    .Clk              (Clk),
    .Reset            (Reset),
    .rs_ID            (rs_ID),
    .rt_ID            (rt_ID),
    .UsesRs_ID        (UsesRs_ID),
    .UsesRt_ID        (UsesRt_ID),
    .BranchID         (BranchID),
    .TakenID          (TakenID),
    .writeRegisterEX  (writeRegisterEX),
    .RegWriteEX       (RegWriteEX),
    .MemReadEX        (MemReadEX),
    .writeRegisterMEM (writeRegisterMEM),
    .MemReadMEM       (MemReadMEM),
    .MultiCycleEX     (MultiCycleEX),
    .PCWrite          (PCWrite),
    .IFIDWrite        (IFIDWrite),
    .IDEXWrite        (IDEXWrite),
    .IDEXBubble       (IDEXBubble),
    .IFIDFlush        (IFIDFlush),
    .EXMEMBubble      (EXMEMBubble),
    .MulDone          (MulDone)
`ifdef HAZARD_PERF_CNT_EN
    ,
    .StallCount       (StallCount),
    .FlushCount       (FlushCount)
`endif
  );

  always #5 Clk = ~Clk;

  // Expected {PCWrite, IFIDWrite, IDEXWrite, IDEXBubble, IFIDFlush, EXMEMBubble, MulDone}
  localparam logic [6:0] NORM = 7'b1110000;
  localparam logic [6:0] LU   = 7'b0011000;
  localparam logic [6:0] MC   = 7'b0000010;
  localparam logic [6:0] FL   = 7'b1110100;
  localparam logic [6:0] DN   = 7'b1110001;
  localparam logic [6:0] LUDN = 7'b0011001;

  logic [6:0] exp_q[$];
  string      name_q[$];
  int checks   = 0;
  int failures = 0;

  task automatic clr_in();
    Reset = 1'b1; rs_ID = 5'd0; rt_ID = 5'd0; UsesRs_ID = 1'b0; UsesRt_ID = 1'b0;
    BranchID = 1'b0; TakenID = 1'b0; writeRegisterEX = 5'd0; RegWriteEX = 1'b0;
    MemReadEX = 2'b00; writeRegisterMEM = 5'd0; MemReadMEM = 2'b00; MultiCycleEX = 1'b0;
  endtask

  task automatic nxt();
    @(posedge Clk);
    #1;
    clr_in();
  endtask

  task automatic expect_out(input string nm, input logic [6:0] e);
    exp_q.push_back(e);
    name_q.push_back(nm);
`ifdef HAZARD_PERF_CNT_EN
    if (!Reset) begin
      exp_stall_cnt = 0;
      exp_flush_cnt = 0;
    end else begin
      if (!e[6]) exp_stall_cnt++;
      if (e[2])  exp_flush_cnt++;
    end
`endif
  endtask

  // Monitor: every cycle the DUT presents a full output vector.
  always @(negedge Clk) begin
    if (exp_q.size() > 0) begin
      logic [6:0] e, a;
      string nm;
      e  = exp_q.pop_front();
      nm = name_q.pop_front();
      a  = {PCWrite, IFIDWrite, IDEXWrite, IDEXBubble, IFIDFlush, EXMEMBubble, MulDone};
      checks++;
      if (a !== e) begin
        failures++;
        $display("FAIL %s: got %b expected %b", nm, a, e);
      end
    end
  end

  initial begin
    clr_in();
    Reset = 1'b0;

    nxt(); Reset = 1'b0; expect_out("reset0", NORM);
    nxt(); Reset = 1'b0; MultiCycleEX = 1'b1; expect_out("reset_mc_masked", NORM);
    nxt(); expect_out("idle", NORM);

    // Load-use: lw $8 in EX, ID reads $8 via rs
    nxt(); MemReadEX = 2'd1; RegWriteEX = 1'b1; writeRegisterEX = 5'd8;
           rs_ID = 5'd8; UsesRs_ID = 1'b1; expect_out("load_use", LU);
    nxt(); rs_ID = 5'd8; UsesRs_ID = 1'b1; expect_out("load_use_after", NORM);
    nxt(); MemReadEX = 2'd2; RegWriteEX = 1'b1; writeRegisterEX = 5'd0;
           rs_ID = 5'd0; UsesRs_ID = 1'b1; expect_out("reg0_no_stall", NORM);
    nxt(); MemReadEX = 2'd1; RegWriteEX = 1'b1; writeRegisterEX = 5'd8;
           rs_ID = 5'd8; UsesRs_ID = 1'b0; expect_out("rs_unused", NORM);
    nxt(); MemReadEX = 2'd3; RegWriteEX = 1'b1; writeRegisterEX = 5'd12;
           rt_ID = 5'd12; UsesRt_ID = 1'b1; expect_out("load_use_rt", LU);

    // Branch on a load: EX cycle, then MEM cycle, then taken redirect flushes
    nxt(); BranchID = 1'b1; TakenID = 1'b1; rt_ID = 5'd9; UsesRt_ID = 1'b1;
           MemReadEX = 2'd1; RegWriteEX = 1'b1; writeRegisterEX = 5'd9;
           expect_out("br_load_ex", LU);
    nxt(); BranchID = 1'b1; TakenID = 1'b1; rt_ID = 5'd9; UsesRt_ID = 1'b1;
           MemReadMEM = 2'd1; writeRegisterMEM = 5'd9; expect_out("br_load_mem", LU);
    nxt(); BranchID = 1'b1; TakenID = 1'b1; rt_ID = 5'd9; UsesRt_ID = 1'b1;
           expect_out("br_taken_flush", FL);
    nxt(); expect_out("after_flush", NORM);

    // ALU result in EX only hazards a branch; MEM load only hazards a branch
    nxt(); BranchID = 1'b1; rs_ID = 5'd5; UsesRs_ID = 1'b1;
           RegWriteEX = 1'b1; writeRegisterEX = 5'd5; expect_out("br_alu_ex", LU);
    nxt(); rs_ID = 5'd5; UsesRs_ID = 1'b1; RegWriteEX = 1'b1; writeRegisterEX = 5'd5;
           expect_out("alu_ex_no_branch", NORM);
    nxt(); rs_ID = 5'd6; UsesRs_ID = 1'b1; MemReadMEM = 2'd1; writeRegisterMEM = 5'd6;
           expect_out("mem_load_no_branch", NORM);
    nxt(); BranchID = 1'b1; rs_ID = 5'd6; UsesRs_ID = 1'b1; writeRegisterMEM = 5'd6;
           expect_out("mem_noload_branch", NORM);
    nxt(); TakenID = 1'b1; expect_out("jump_flush", FL);

    // Multi-cycle op: 4 stall cycles, one DONE, no re-trigger
    for (int i = 0; i < 4; i++) begin
      nxt(); MultiCycleEX = 1'b1; expect_out($sformatf("mc_stall%0d", i), MC);
    end
    nxt(); MultiCycleEX = 1'b1; expect_out("mc_done", DN);
    nxt(); expect_out("mc_idle", NORM);
    nxt(); expect_out("mc_no_retrigger", NORM);

    // Priority: load-use during mul/div hold never bubbles ID/EX
    for (int i = 0; i < 4; i++) begin
      nxt(); MultiCycleEX = 1'b1; MemReadEX = 2'd1; RegWriteEX = 1'b1;
             writeRegisterEX = 5'd8; rs_ID = 5'd8; UsesRs_ID = 1'b1; TakenID = 1'b1;
             expect_out($sformatf("prio_mc%0d", i), MC);
    end
    nxt(); MultiCycleEX = 1'b1; MemReadEX = 2'd1; RegWriteEX = 1'b1;
           writeRegisterEX = 5'd8; rs_ID = 5'd8; UsesRs_ID = 1'b1;
           expect_out("prio_done_lu", LUDN);
    nxt(); expect_out("prio_idle", NORM);

    // Reset during BUSY abandons the op without MulDone
    nxt(); MultiCycleEX = 1'b1; expect_out("rstmc_idle", MC);
    nxt(); MultiCycleEX = 1'b1; expect_out("rstmc_busy1", MC);
    nxt(); MultiCycleEX = 1'b1; Reset = 1'b0; expect_out("rstmc_reset", NORM);
    for (int i = 0; i < 4; i++) begin
      nxt(); expect_out($sformatf("rstmc_no_done%0d", i), NORM);
    end
    nxt(); TakenID = 1'b1; expect_out("final_flush", FL);
    nxt(); expect_out("final_idle", NORM);

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge Clk);
    @(posedge Clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain: %0d entries left expected 0", exp_q.size());
    end
`ifdef HAZARD_PERF_CNT_EN
    checks++;
    if (StallCount !== 32'(exp_stall_cnt)) begin
      failures++;
      $display("FAIL stall_count: got %0d expected %0d", StallCount, exp_stall_cnt);
    end
    checks++;
    if (FlushCount !== 32'(exp_flush_cnt)) begin
      failures++;
      $display("FAIL flush_count: got %0d expected %0d", FlushCount, exp_flush_cnt);
    end
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
